// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write arbiter: FSM encoding, default
// bus timing, counter width and the HD44780 slow-command codes.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_DONE
  } lcd_state_e;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_E_CYC     = 12;
  localparam int DEF_HOLD_CYC  = 2;
  localparam int DEF_GAP_CYC   = 2000;
  localparam int DEF_CLEAR_CYC = 82000;

  localparam int CNT_W = 18;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // A phase of N cycles loads the down-counter with N-1; zero behaves like one.
  function automatic cnt_t cycLoad(input int cyc);
    if (cyc <= 1) begin
      return '0;
    end
    return cnt_t'(cyc - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin pick: the search starts at ptr_i and wraps, giving a
// one-hot grant plus the binary index of the winner. Purely combinational.
module rr_arbiter3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] gnt_o,
  output logic [1:0] idx_o
);

  // Walk the requesters in rotated priority order starting at the pointer.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    case (ptr_i)
      2'd1: begin
        if (req_i[1])      begin gnt_o = 3'b010; idx_o = 2'd1; end
        else if (req_i[2]) begin gnt_o = 3'b100; idx_o = 2'd2; end
        else if (req_i[0]) begin gnt_o = 3'b001; idx_o = 2'd0; end
      end
      2'd2: begin
        if (req_i[2])      begin gnt_o = 3'b100; idx_o = 2'd2; end
        else if (req_i[0]) begin gnt_o = 3'b001; idx_o = 2'd0; end
        else if (req_i[1]) begin gnt_o = 3'b010; idx_o = 2'd1; end
      end
      default: begin
        if (req_i[0])      begin gnt_o = 3'b001; idx_o = 2'd0; end
        else if (req_i[1]) begin gnt_o = 3'b010; idx_o = 2'd1; end
        else if (req_i[2]) begin gnt_o = 3'b100; idx_o = 2'd2; end
      end
    endcase
  end

endmodule

// File: rtl/lcd_arbiter.sv
// LCD write arbiter: shares one character LCD between three requesters.
// The winner's byte is latched, then one write cycle is sequenced
// (setup, enable pulse, hold, settle) before done pulses back to it.
module lcd_arbiter
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int E_CYC     = DEF_E_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int CLEAR_CYC = DEF_CLEAR_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_rs,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [7:0]  lcd_data
);

  localparam cnt_t SETUP_LD = cycLoad(SETUP_CYC);
  localparam cnt_t E_LD     = cycLoad(E_CYC);
  localparam cnt_t HOLD_LD  = cycLoad(HOLD_CYC);
  localparam cnt_t GAP_LD   = cycLoad(GAP_CYC);
  localparam cnt_t CLEAR_LD = cycLoad(CLEAR_CYC);

  lcd_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] byte_q, byte_d;
  logic       rs_q, rs_d;

  logic [2:0] winGnt;
  logic [1:0] winIdx;
  logic [7:0] winData;
  logic       winRs;
  logic       isSlow;
  logic       onBus;

  rr_arbiter3 uArb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (winGnt),
    .idx_o (winIdx)
  );

  // Route the winning requester's byte and register select to the latch.
  always_comb begin
    winData = req_data[7:0];
    winRs   = req_rs[0];
    case (winIdx)
      2'd1:    begin winData = req_data[15:8];  winRs = req_rs[1]; end
      2'd2:    begin winData = req_data[23:16]; winRs = req_rs[2]; end
      default: begin winData = req_data[7:0];   winRs = req_rs[0]; end
    endcase
  end

  assign isSlow = !rs_q && ((byte_q == CMD_CLEAR) || (byte_q == CMD_HOME));

  // State, counter, pointer and latched write; reset also kills a write in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
    end
  end

  // Next-state logic: each timed phase counts down to zero, then advances.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 3'b000) begin
          byte_d  = winData;
          rs_d    = winRs;
          grant_d = winGnt;
          ptr_d   = (winIdx == 2'd2) ? 2'd0 : winIdx + 2'd1;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = E_LD;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = isSlow ? CLEAR_LD : GAP_LD;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        byte_d  = '0;
        rs_d    = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin and handshake outputs decode directly from state so reset clears them at once.
  always_comb begin
    onBus    = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
               (state_q == ST_HOLD)  || (state_q == ST_WAIT);
    busy     = (state_q != ST_IDLE);
    lcd_e    = (state_q == ST_PULSE);
    lcd_rw   = 1'b0;
    lcd_rs   = onBus ? rs_q : 1'b0;
    lcd_data = onBus ? byte_q : 8'h00;
    grant    = grant_q;
    done     = (state_q == ST_DONE) ? grant_q : 3'b000;
  end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Directed bench for lcd_arbiter with short timing (setup 2, E 12, hold 2,
// gap 20, clear 50). Outputs are sampled on the falling edge.
module tb_lcd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_rs = '0;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_arbiter #(
    .SETUP_CYC (2),
    .E_CYC     (12),
    .HOLD_CYC  (2),
    .GAP_CYC   (20),
    .CLEAR_CYC (50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_rs   (req_rs),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [23:0] d, input logic [2:0] s);
    req      = r;
    req_data = d;
    req_rs   = s;
  endtask

  task automatic waitIdle(input string tag);
    int c = 0;
    while (busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // One full write. Offset 0 is the first falling edge after the grant edge;
  // the grant cycle is the first of 17+wait cycles, done pulsing in the last.
  // At chgAt, req is dropped and req_data replaced by chgData.
  task automatic runTxn(input string tag, input logic [2:0] r, input logic [23:0] d,
                        input logic [2:0] s, input logic [2:0] expGrant,
                        input logic [7:0] expData, input logic expRs,
                        input int waitCyc, input int chgAt, input logic [23:0] chgData);
    int eStart = -1;
    int eCount = 0;
    int doneAt = -1;
    int doneCount = 0;
    int grantCycles = 0;
    int dataBad = 0;
    logic [2:0] doneVal = '0;
    applyStimulus(r, d, s);
    @(negedge clk);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(expGrant));
    checkOutput({tag, ".data0"}, 32'(lcd_data), 32'(expData));
    checkOutput({tag, ".rs0"}, 32'(lcd_rs), 32'(expRs));
    checkOutput({tag, ".e0"}, 32'(lcd_e), 32'd0);
    checkOutput({tag, ".rw"}, 32'(lcd_rw), 32'd0);
    for (int off = 0; off <= 21 + waitCyc; off++) begin
      if (grant != 3'b000) grantCycles++;
      if (lcd_e) begin
        if (eStart < 0) eStart = off;
        eCount++;
      end
      if (busy && done == 3'b000 && lcd_data !== expData) dataBad++;
      if (done != 3'b000) begin
        doneAt = off;
        doneCount++;
        doneVal = done;
      end
      if (off == chgAt) applyStimulus(3'b000, chgData, s);
      @(negedge clk);
      if (doneAt >= 0) break;
    end
    checkOutput({tag, ".eStart"}, 32'(eStart), 32'd2);
    checkOutput({tag, ".eCount"}, 32'(eCount), 32'd12);
    checkOutput({tag, ".doneAt"}, 32'(doneAt), 32'(16 + waitCyc));
    checkOutput({tag, ".grantCycles"}, 32'(grantCycles), 32'(17 + waitCyc));
    checkOutput({tag, ".doneVal"}, 32'(doneVal), 32'(expGrant));
    checkOutput({tag, ".doneCount"}, 32'(doneCount), 32'd1);
    checkOutput({tag, ".dataHeld"}, 32'(dataBad), 32'd0);
    checkOutput({tag, ".grantAfter"}, 32'(grant), 32'd0);
    checkOutput({tag, ".busyAfter"}, 32'(busy), 32'd0);
  endtask

  // Start a write from requester mask r and stop at its first lcd_e cycle.
  task automatic reachPulse(input string tag, input logic [2:0] r);
    int c = 0;
    applyStimulus(r, 24'h00_99_00, 3'b000);
    @(negedge clk);
    applyStimulus(3'b000, 24'h00_99_00, 3'b000);
    while (!lcd_e && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 32'(lcd_e), 32'd1);
  endtask

  initial begin
    logic [2:0] seq [4];
    logic [2:0] prev;
    int n;
    int zeroRun;
    int firstGap;

    // Reset state.
    applyStimulus(3'b000, 24'h0, 3'b000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst.grant", 32'(grant), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.e", 32'(lcd_e), 32'd0);
    checkOutput("rst.data", 32'(lcd_data), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle.busy", 32'(busy), 32'd0);

    // Single data write, then clear command, drop-during-pulse, data change in setup.
    runTxn("single", 3'b001, 24'h00_00_41, 3'b001, 3'b001, 8'h41, 1'b1, 20, 0, 24'h00_00_41);
    runTxn("clear", 3'b010, 24'h00_01_00, 3'b000, 3'b010, 8'h01, 1'b0, 50, 0, 24'h00_01_00);
    runTxn("dropPulse", 3'b100, 24'h55_00_00, 3'b100, 3'b100, 8'h55, 1'b1, 20, 5, 24'h55_00_00);
    runTxn("dataChange", 3'b001, 24'h00_00_41, 3'b001, 3'b001, 8'h41, 1'b1, 20, 1, 24'h00_00_42);

    // All three requesting from reset: strict rotation with one idle cycle between.
    rst = 1'b0;
    applyStimulus(3'b111, 24'h32_31_30, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    prev = '0;
    n = 0;
    zeroRun = 0;
    firstGap = -1;
    for (int c = 0; c < 400 && n < 4; c++) begin
      @(negedge clk);
      if (grant != 3'b000 && prev == 3'b000) begin
        seq[n] = grant;
        if (n == 1) firstGap = zeroRun;
        n++;
      end
      if (grant == 3'b000) zeroRun++;
      else zeroRun = 0;
      prev = grant;
    end
    checkOutput("rr.count", 32'(n), 32'd4);
    checkOutput("rr.g0", 32'(seq[0]), 32'd1);
    checkOutput("rr.g1", 32'(seq[1]), 32'd2);
    checkOutput("rr.g2", 32'(seq[2]), 32'd4);
    checkOutput("rr.g3", 32'(seq[3]), 32'd1);
    checkOutput("rr.idleGap", 32'(firstGap), 32'd1);
    applyStimulus(3'b000, 24'h0, 3'b000);
    waitIdle("rr.drain");

    // Reset in the middle of an enable pulse.
    reachPulse("rstPulse.reach", 3'b010);
    rst = 1'b0;
    applyStimulus(3'b100, 24'h0, 3'b000);
    @(negedge clk);
    checkOutput("rstPulse.e", 32'(lcd_e), 32'd0);
    checkOutput("rstPulse.grant", 32'(grant), 32'd0);
    checkOutput("rstPulse.busy", 32'(busy), 32'd0);
    checkOutput("rstPulse.data", 32'(lcd_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstPulse.regrant", 32'(grant), 32'd4);
    applyStimulus(3'b000, 24'h0, 3'b000);
    waitIdle("rstPulse.drain");

    // Pointer is cleared by reset: after a grant to 1 (pointer 2), 101 must go to 0.
    reachPulse("rstPtr.reach", 3'b010);
    rst = 1'b0;
    applyStimulus(3'b101, 24'h0, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstPtr.grant", 32'(grant), 32'd1);
    applyStimulus(3'b000, 24'h0, 3'b000);
    waitIdle("rstPtr.drain");

    // 0x01 as data is not a clear; home command takes the long wait.
    runTxn("dataOne", 3'b010, 24'h00_01_00, 3'b010, 3'b010, 8'h01, 1'b1, 20, 0, 24'h00_01_00);
    runTxn("home", 3'b100, 24'h02_00_00, 3'b000, 3'b100, 8'h02, 1'b0, 50, 0, 24'h02_00_00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
